// File: rtl/treeval_pkg.sv
// Shared definitions for the treeval command path: message geometry,
// command-type encodings and the arbiter session state encoding.
package treeval_pkg;

    localparam int W_MSG      = 64;
    localparam int W_CMD_TYPE = 2;

    // Command type lives in the top W_CMD_TYPE bits of every message.
    localparam logic [W_CMD_TYPE-1:0] CMD_RUN_COMPUTATION = 2'd0;
    localparam logic [W_CMD_TYPE-1:0] CMD_SET_NODE_DATA   = 2'd1;
    localparam logic [W_CMD_TYPE-1:0] CMD_SET_CONFIG_DATA = 2'd2;

    // Session states of the message arbiter.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FWD         = 3'd1,
        ST_WAIT_NEXT   = 3'd2,
        ST_WAIT_RESULT = 3'd3,
        ST_RETURN      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/treeval_rr_pick.sv
// Combinational round-robin picker: returns the first eligible requester
// at or after rr_ptr (wrapping). Requesters flagged in guard are skipped.
module treeval_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    input  logic [N_REQ-1:0]         guard,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] elig_s;

    assign elig_s = req & ~guard;

    // Walk the requesters starting at rr_ptr and keep the first eligible one
    always_comb begin
        int  pos_s;
        logic hit_s;
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        pos_s = 0;
        hit_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            pos_s = int'(rr_ptr) + i;
            pos_s = (pos_s >= N_REQ) ? (pos_s - N_REQ) : pos_s;
            hit_s = elig_s[pos_s] & ~valid;
            valid = valid | hit_s;
            idx   = hit_s ? IDX_W'(pos_s) : idx;
        end
    end

endmodule

// File: rtl/treeval_msg_arbiter.sv
// Shares the single treeval_controller command channel among N_REQ
// requesters. A grant locks the channel to one requester for a whole
// session (config/node messages followed by a run) and the controller's
// result is routed back to that requester. Idle sessions that never issue
// a run are released after LOCK_TIMEOUT quiet cycles.
module treeval_msg_arbiter #(
    parameter int N_REQ        = 4,
    parameter int W_MSG        = treeval_pkg::W_MSG,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_msg_rdy,
    input  logic [N_REQ*W_MSG-1:0]   req_msg,
    output logic [N_REQ-1:0]         req_msg_ack,
    output logic [N_REQ-1:0]         req_out_rdy,
    output logic [W_MSG-1:0]         req_out_msg,
    input  logic [N_REQ-1:0]         req_out_ack,
    output logic                     in_msg_rdy,
    output logic [W_MSG-1:0]         in_msg,
    input  logic                     in_msg_ack,
    input  logic                     out_msg_rdy,
    input  logic [W_MSG-1:0]         out_msg,
    output logic                     out_msg_ack,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     err_orphan
);

    import treeval_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;

    // One-hot vector with a single bit set at idx.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = {N_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    arb_state_t       state_r, state_nxt_s;
    logic [IDX_W-1:0] owner_r, owner_nxt_s;
    logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic [IDX_W-1:0] owner_inc_s, cap_idx_s, pick_idx_s;
    logic [CNT_W-1:0] idle_cnt_r, idle_cnt_nxt_s, idle_cnt_inc_s;
    logic [W_MSG-1:0] msg_q_r, sel_msg_s, result_r;
    logic [N_REQ-1:0] req_msg_ack_r, req_out_rdy_r;
    logic             in_msg_rdy_r, out_msg_ack_r, busy_r, err_orphan_r;
    logic             pick_valid_s, owner_rdy_s, out_take_s, timeout_hit_s;
    logic             capture_s, res_cap_s;
    logic [W_CMD_TYPE-1:0] fwd_cmd_s;

    // Requesters acked last cycle still show a stale rdy; mask them out.
    treeval_rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req_msg_rdy),
        .rr_ptr (rr_ptr_r),
        .guard  (req_msg_ack_r),
        .valid  (pick_valid_s),
        .idx    (pick_idx_s)
    );

    // The controller drops out_msg_rdy only after seeing our ack, so the
    // cycle with the ack high is not a new result.
    assign out_take_s     = out_msg_rdy & ~out_msg_ack_r;
    assign owner_rdy_s    = req_msg_rdy[owner_r] & ~req_msg_ack_r[owner_r];
    assign owner_inc_s    = (owner_r == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : (owner_r + IDX_W'(1));
    assign idle_cnt_inc_s = (idle_cnt_r == {CNT_W{1'b1}}) ? idle_cnt_r : (idle_cnt_r + CNT_W'(1));
    assign timeout_hit_s  = (idle_cnt_inc_s >= CNT_W'(LOCK_TIMEOUT - 1));
    assign cap_idx_s      = (state_r == ST_IDLE) ? pick_idx_s : owner_r;
    assign fwd_cmd_s      = msg_q_r[W_MSG-1 -: W_CMD_TYPE];

    // Select the message slice of the requester being captured this cycle
    always_comb begin
        sel_msg_s = {W_MSG{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            sel_msg_s = (cap_idx_s == IDX_W'(i)) ? req_msg[i*W_MSG +: W_MSG] : sel_msg_s;
        end
    end

    // Session FSM: next state, owner, round-robin pointer and idle counter
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        idle_cnt_nxt_s = idle_cnt_r;
        capture_s      = 1'b0;
        res_cap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    owner_nxt_s = pick_idx_s;
                    capture_s   = 1'b1;
                    state_nxt_s = ST_FWD;
                end else begin
                    owner_nxt_s = {IDX_W{1'b0}};
                end
            end
            ST_FWD: begin
                if (in_msg_ack) begin
                    if (fwd_cmd_s == CMD_RUN_COMPUTATION) begin
                        state_nxt_s = ST_WAIT_RESULT;
                    end else begin
                        state_nxt_s    = ST_WAIT_NEXT;
                        idle_cnt_nxt_s = {CNT_W{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_FWD;
                end
            end
            ST_WAIT_NEXT: begin
                // A request from the owner beats a timeout in the same cycle.
                if (owner_rdy_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_FWD;
                end else begin
                    idle_cnt_nxt_s = idle_cnt_inc_s;
                    if (timeout_hit_s) begin
                        state_nxt_s  = ST_IDLE;
                        rr_ptr_nxt_s = owner_inc_s;
                        owner_nxt_s  = {IDX_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_WAIT_NEXT;
                    end
                end
            end
            ST_WAIT_RESULT: begin
                if (out_take_s) begin
                    res_cap_s   = 1'b1;
                    state_nxt_s = ST_RETURN;
                end else begin
                    state_nxt_s = ST_WAIT_RESULT;
                end
            end
            ST_RETURN: begin
                if (req_out_ack[owner_r]) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = owner_inc_s;
                    owner_nxt_s  = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = ST_RETURN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                owner_nxt_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Session state and bookkeeping registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= {IDX_W{1'b0}};
            rr_ptr_r   <= {IDX_W{1'b0}};
            idle_cnt_r <= {CNT_W{1'b0}};
            msg_q_r    <= {W_MSG{1'b0}};
            result_r   <= {W_MSG{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            idle_cnt_r <= idle_cnt_nxt_s;
            msg_q_r    <= capture_s ? sel_msg_s : msg_q_r;
            result_r   <= res_cap_s ? out_msg : result_r;
        end
    end

    // Handshake and status outputs, registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_msg_ack_r <= {N_REQ{1'b0}};
            req_out_rdy_r <= {N_REQ{1'b0}};
            in_msg_rdy_r  <= 1'b0;
            out_msg_ack_r <= 1'b0;
            busy_r        <= 1'b0;
            err_orphan_r  <= 1'b0;
        end else begin
            req_msg_ack_r <= capture_s ? idx_onehot(cap_idx_s) : {N_REQ{1'b0}};
            req_out_rdy_r <= (state_nxt_s == ST_RETURN) ? idx_onehot(owner_nxt_s) : {N_REQ{1'b0}};
            in_msg_rdy_r  <= (state_nxt_s == ST_FWD);
            out_msg_ack_r <= out_take_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            err_orphan_r  <= err_orphan_r | (out_take_s & (state_r != ST_WAIT_RESULT));
        end
    end

    assign req_msg_ack = req_msg_ack_r;
    assign req_out_rdy = req_out_rdy_r;
    assign req_out_msg = result_r;
    assign in_msg_rdy  = in_msg_rdy_r;
    assign in_msg      = msg_q_r;
    assign out_msg_ack = out_msg_ack_r;
    assign busy        = busy_r;
    assign owner       = owner_r;
    assign err_orphan  = err_orphan_r;

endmodule

// File: tb/tb_treeval_msg_arbiter.sv
// Directed bench for treeval_msg_arbiter with two requesters: single
// session, contention, lock timeout, back-pressure, orphan result and
// mid-run reset.
module tb_treeval_msg_arbiter;

    localparam int NR = 2;
    localparam int WM = 64;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_msg_rdy;
    logic [NR*WM-1:0] req_msg;
    logic [NR-1:0]   req_msg_ack;
    logic [NR-1:0]   req_out_rdy;
    logic [WM-1:0]   req_out_msg;
    logic [NR-1:0]   req_out_ack;
    logic            in_msg_rdy;
    logic [WM-1:0]   in_msg;
    logic            in_msg_ack;
    logic            out_msg_rdy;
    logic [WM-1:0]   out_msg;
    logic            out_msg_ack;
    logic            busy;
    logic            owner;
    logic            err_orphan;

    int vectors     = 0;
    int miscompares = 0;
    int ack0_cnt    = 0;

    treeval_msg_arbiter #(
        .N_REQ        (NR),
        .W_MSG        (WM),
        .LOCK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_msg_rdy (req_msg_rdy),
        .req_msg     (req_msg),
        .req_msg_ack (req_msg_ack),
        .req_out_rdy (req_out_rdy),
        .req_out_msg (req_out_msg),
        .req_out_ack (req_out_ack),
        .in_msg_rdy  (in_msg_rdy),
        .in_msg      (in_msg),
        .in_msg_ack  (in_msg_ack),
        .out_msg_rdy (out_msg_rdy),
        .out_msg     (out_msg),
        .out_msg_ack (out_msg_ack),
        .busy        (busy),
        .owner       (owner),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ack pulses to requester 0, sampled mid-cycle
    always @(negedge clk) begin
        if (req_msg_ack[0] === 1'b1) ack0_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_req(input int i, input logic [63:0] m);
        req_msg[i*WM +: WM] = m;
        req_msg_rdy[i]      = 1'b1;
    endtask

    task automatic drop_req(input int i);
        req_msg_rdy[i] = 1'b0;
    endtask

    // Tick until requester i is acked or the bound runs out
    task automatic wait_grant(input int i, input int bound, output int n);
        n = 0;
        while (req_msg_ack[i] !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
    endtask

    // Controller accepts the forwarded word with a one-cycle ack
    task automatic ctl_accept();
        in_msg_ack = 1'b1;
        tick();
        in_msg_ack = 1'b0;
    endtask

    // Controller returns a result, holds rdy through the ack, then the
    // owner consumes it
    task automatic ctl_result(input logic [63:0] r, input logic [NR-1:0] who, input string tag);
        out_msg_rdy = 1'b1;
        out_msg     = r;
        tick();
        chk({tag, "_out_ack"}, out_msg_ack, 1);
        chk({tag, "_out_rdy"}, req_out_rdy, who);
        chk({tag, "_out_msg"}, req_out_msg, r);
        tick();
        chk({tag, "_no_dup_ack"}, out_msg_ack, 0);
        out_msg_rdy = 1'b0;
        req_out_ack = who;
        tick();
        req_out_ack = {NR{1'b0}};
        chk({tag, "_out_rdy_clr"}, req_out_rdy, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    logic [63:0] sess[8];
    int          n;
    int          a0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        req_msg_rdy = {NR{1'b0}};
        req_msg     = {(NR*WM){1'b0}};
        req_out_ack = {NR{1'b0}};
        in_msg_ack  = 1'b0;
        out_msg_rdy = 1'b0;
        out_msg     = 64'h0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_in_rdy", in_msg_rdy, 0);
        chk("rst_in_msg", in_msg, 0);
        chk("rst_req_ack", req_msg_ack, 0);
        chk("rst_out_rdy", req_out_rdy, 0);
        chk("rst_out_ack", out_msg_ack, 0);
        chk("rst_orphan", err_orphan, 0);
        rst = 1'b1;
        tick();

        // Single session: config (7 nodes), six node messages, run
        sess[0] = {2'b10, 62'd7};
        for (int j = 1; j < 7; j++) sess[j] = {2'b01, 30'd0, 32'(j)};
        sess[7] = {2'b00, 62'd0};
        for (int j = 0; j < 8; j++) begin
            put_req(0, sess[j]);
            tick();
            chk("sess_ack", req_msg_ack, 2'b01);
            chk("sess_fwd_rdy", in_msg_rdy, 1);
            chk("sess_fwd_msg", in_msg, sess[j]);
            drop_req(0);
            ctl_accept();
            chk("sess_fwd_drop", in_msg_rdy, 0);
            chk("sess_busy", busy, 1);
        end
        ctl_result(64'h7, 2'b01, "sess");
        chk("sess_ack0_count", ack0_cnt, 8);

        // Contention from reset: req0 first, req1 waits for the whole session
        rst = 1'b0;
        tick();
        rst = 1'b1;
        put_req(0, {2'b00, 62'h11});
        put_req(1, {2'b00, 62'h22});
        tick();
        chk("cont_ack0", req_msg_ack, 2'b01);
        chk("cont_owner0", owner, 0);
        chk("cont_msg0", in_msg, {2'b00, 62'h11});
        drop_req(0);
        ctl_accept();
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("cont_req1_held", req_msg_ack, 2'b00);
        end
        out_msg_rdy = 1'b1;
        out_msg     = 64'h55;
        tick();
        chk("cont_res0", req_out_rdy, 2'b01);
        tick();
        out_msg_rdy = 1'b0;
        req_out_ack = 2'b01;
        tick();
        req_out_ack = 2'b00;
        chk("cont_ret_idle", req_msg_ack, 2'b00);
        tick();
        chk("cont_ack1", req_msg_ack, 2'b10);
        chk("cont_owner1", owner, 1);
        chk("cont_msg1", in_msg, {2'b00, 62'h22});
        drop_req(1);
        ctl_accept();
        ctl_result(64'h66, 2'b10, "cont1");

        // Lock timeout: req0 goes quiet while req1 holds rdy
        put_req(0, {2'b01, 62'h101});
        tick();
        chk("lock_ack0", req_msg_ack, 2'b01);
        drop_req(0);
        put_req(1, {2'b01, 62'h202});
        ctl_accept();
        wait_grant(1, 40, n);
        chk("lock_grant_delay1", n, 16);
        chk("lock_ack1", req_msg_ack, 2'b10);
        chk("lock_msg1", in_msg, {2'b01, 62'h202});
        put_req(0, {2'b01, 62'h303});
        drop_req(1);
        ctl_accept();
        wait_grant(0, 40, n);
        chk("lock_grant_delay0", n, 16);
        chk("lock_owner0", owner, 0);
        chk("lock_msg0", in_msg, {2'b01, 62'h303});

        // Owner request in the timeout cycle keeps the lock
        drop_req(0);
        ctl_accept();
        repeat (14) tick();
        put_req(0, {2'b10, 62'h404});
        tick();
        chk("race_ack0", req_msg_ack, 2'b01);
        chk("race_busy", busy, 1);
        chk("race_msg", in_msg, {2'b10, 62'h404});
        drop_req(0);
        ctl_accept();

        // Back-pressure: controller withholds its ack for 10 cycles
        a0 = ack0_cnt;
        put_req(0, {2'b00, 62'h505});
        tick();
        chk("bp_ack", req_msg_ack, 2'b01);
        drop_req(0);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("bp_msg_stable", in_msg, {2'b00, 62'h505});
            chk("bp_rdy_held", in_msg_rdy, 1);
        end
        chk("bp_single_ack", ack0_cnt - a0, 1);
        ctl_accept();
        chk("bp_rdy_drop", in_msg_rdy, 0);
        ctl_result(64'h99, 2'b01, "bp");
        chk("bp_no_orphan", err_orphan, 0);

        // Orphan result while idle
        out_msg_rdy = 1'b1;
        out_msg     = 64'hAA;
        tick();
        chk("orph_ack", out_msg_ack, 1);
        chk("orph_flag", err_orphan, 1);
        chk("orph_no_out", req_out_rdy, 0);
        chk("orph_idle", busy, 0);
        tick();
        out_msg_rdy = 1'b0;
        chk("orph_ack_once", out_msg_ack, 0);
        tick();
        chk("orph_sticky", err_orphan, 1);

        // Reset while a message is being forwarded
        put_req(1, {2'b01, 62'h606});
        tick();
        chk("mrst_fwd", in_msg_rdy, 1);
        chk("mrst_owner", owner, 1);
        drop_req(1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mrst_in_rdy", in_msg_rdy, 0);
        chk("mrst_in_msg", in_msg, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_owner0", owner, 0);
        chk("mrst_orphan", err_orphan, 0);
        chk("mrst_req_ack", req_msg_ack, 0);
        tick();
        chk("mrst_discard", in_msg_rdy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
